// File: rtl/ecc_codec_engine.sv
// ecc_codec_engine: extended-Hamming SECDED encode / decode / full-channel engine.
// Codeword bit i (1..N-1) is Hamming position i, bit 0 is overall even parity.
module ecc_codec_engine #(
    parameter int AMBA_WORD = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AMBA_WORD-1:0] CTRL,
    input  logic [AMBA_WORD-1:0] DATA_IN,
    input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
    input  logic [AMBA_WORD-1:0] NOISE,
    output logic [AMBA_WORD-1:0] data_out,
    output logic                 operation_done,
    output logic [1:0]           num_of_errors,
    output logic                 busy
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ENC  = 3'd1;
    localparam logic [2:0] CHAN = 3'd2;
    localparam logic [2:0] DEC  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    function automatic int cw_len(input logic [1:0] w);
        return (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
    endfunction

    function automatic logic [31:0] cw_mask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    function automatic logic [31:0] encode(input logic [31:0] d, input int n);
        logic [31:0] c;
        logic [4:0]  j;
        logic        p;
        c = '0;
        j = '0;
        for (int i = 1; i < 32; i++) begin
            if (i < n && (i & (i - 1)) != 0) begin
                c[i] = d[j];
                j = j + 5'd1;
            end
        end
        // parity slots are still zero here, so XOR over all members equals XOR over data members
        for (int k = 0; k < 5; k++) begin
            p = 1'b0;
            for (int i = 1; i < 32; i++)
                if (i < n && ((i >> k) & 1) != 0) p = p ^ c[i];
            if ((1 << k) < n) c[1 << k] = p;
        end
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [33:0] decode(input logic [31:0] r, input int n);
        logic [31:0] c;
        logic [31:0] d;
        logic [4:0]  s;
        logic [4:0]  j;
        logic [1:0]  e;
        logic        p;
        c = r & cw_mask(n);
        s = '0;
        for (int i = 1; i < 32; i++)
            if (i < n && c[i]) s = s ^ 5'(i);
        p = ^c;
        e = 2'd0;
        if (p) begin
            if (int'(s) >= n) e = 2'd2;
            else begin
                c[s] = ~c[s];
                e = 2'd1;
            end
        end else if (s != 5'd0) e = 2'd2;
        d = '0;
        j = '0;
        for (int i = 1; i < 32; i++) begin
            if (i < n && (i & (i - 1)) != 0) begin
                d[j] = c[i];
                j = j + 5'd1;
            end
        end
        return {e, d};
    endfunction

    logic [2:0]           state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [1:0]           width_q, width_d;
    logic [31:0]          data_q, data_d;
    logic [31:0]          noise_q, noise_d;
    logic [31:0]          cw_q, cw_d;
    logic [31:0]          res_q, res_d;
    logic [1:0]           err_q, err_d;
    logic [AMBA_WORD-1:0] dout_q, dout_d;
    logic [1:0]           nerr_q, nerr_d;
    logic                 done_q, done_d;
    logic [31:0]          enc_w;
    logic [33:0]          dec_w;
    int                   n_w;
    logic                 unused_ok;

    assign unused_ok = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2]};

    always_comb begin
        n_w     = cw_len(width_q);
        enc_w   = encode(data_q, n_w);
        dec_w   = decode(cw_q, n_w);
        state_d = state_q;
        mode_d  = mode_q;
        width_d = width_q;
        data_d  = data_q;
        noise_d = noise_q;
        cw_d    = cw_q;
        res_d   = res_q;
        err_d   = err_q;
        dout_d  = dout_q;
        nerr_d  = nerr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                mode_d  = CTRL[1:0];
                width_d = CODEWORD_WIDTH[1:0];
                data_d  = DATA_IN[31:0];
                noise_d = NOISE[31:0];
                cw_d    = DATA_IN[31:0];
                res_d   = '0;
                err_d   = 2'd0;
                state_d = (CTRL[1:0] == 2'd1) ? DEC : (CTRL[1:0] == 2'd3) ? DONE : ENC;
            end
            ENC: begin
                cw_d    = enc_w;
                res_d   = enc_w;
                err_d   = 2'd0;
                state_d = (mode_q == 2'd2) ? CHAN : DONE;
            end
            CHAN: begin
                cw_d    = cw_q ^ (noise_q & cw_mask(n_w));
                state_d = DEC;
            end
            DEC: begin
                res_d   = dec_w[31:0];
                err_d   = dec_w[33:32];
                state_d = DONE;
            end
            DONE: begin
                dout_d  = AMBA_WORD'(res_q);
                nerr_d  = err_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            width_q <= '0;
            data_q  <= '0;
            noise_q <= '0;
            cw_q    <= '0;
            res_q   <= '0;
            err_q   <= '0;
            dout_q  <= '0;
            nerr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            width_q <= width_d;
            data_q  <= data_d;
            noise_q <= noise_d;
            cw_q    <= cw_d;
            res_q   <= res_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            nerr_q  <= nerr_d;
            done_q  <= done_d;
        end
    end

    assign data_out       = dout_q;
    assign operation_done = done_q;
    assign num_of_errors  = nerr_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_ecc_codec_engine.sv
// tb_ecc_codec_engine: directed self-checking bench for the SECDED codec engine.
module tb_ecc_codec_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] CTRL = '0;
    logic [31:0] DATA_IN = '0;
    logic [31:0] CODEWORD_WIDTH = '0;
    logic [31:0] NOISE = '0;
    logic [31:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;
    logic        busy;

    int pass_cnt = 0;
    int total = 0;

    ecc_codec_engine #(.AMBA_WORD(32)) dut (
        .clk(clk), .rst(rst), .start(start), .CTRL(CTRL), .DATA_IN(DATA_IN),
        .CODEWORD_WIDTH(CODEWORD_WIDTH), .NOISE(NOISE), .data_out(data_out),
        .operation_done(operation_done), .num_of_errors(num_of_errors), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one operation and waits (bounded) for the done pulse; lat=0 means it never came.
    task automatic run_op(input logic [1:0] ctrl, input logic [1:0] w, input logic [31:0] din,
                          input logic [31:0] noise, output int lat, output logic [31:0] dout,
                          output logic [1:0] nerr, output logic bsy);
        @(negedge clk);
        CTRL = {30'd0, ctrl};
        CODEWORD_WIDTH = {30'd0, w};
        DATA_IN = din;
        NOISE = noise;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bsy = busy;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (operation_done) begin
                lat = c;
                break;
            end
        end
        dout = data_out;
        nerr = num_of_errors;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (data_out !== 32'h0) $display("FAIL reset data_out got %h want 0", data_out); else pass_cnt++;
        total++; if (operation_done !== 1'b0) $display("FAIL reset done got %b want 0", operation_done); else pass_cnt++;
        total++; if (num_of_errors !== 2'd0) $display("FAIL reset errors got %0d want 0", num_of_errors); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_encode;
        int lat; logic [31:0] d; logic [1:0] e; logic b;
        run_op(2'd0, 2'd0, 32'h0000_000B, 32'h0, lat, d, e, b);
        total++; if (b !== 1'b1) $display("FAIL enc8 busy got %b want 1", b); else pass_cnt++;
        total++; if (lat !== 2) $display("FAIL enc8 latency got %0d want 2", lat); else pass_cnt++;
        total++; if (d !== 32'h0000_00AA) $display("FAIL enc8 data got %h want 000000aa", d); else pass_cnt++;
        total++; if (e !== 2'd0) $display("FAIL enc8 errors got %0d want 0", e); else pass_cnt++;
        @(posedge clk);
        #1;
        total++; if (operation_done !== 1'b0) $display("FAIL enc8 done width got %b want 0", operation_done); else pass_cnt++;
        total++; if (data_out !== 32'h0000_00AA) $display("FAIL enc8 hold got %h want 000000aa", data_out); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL enc8 idle busy got %b want 0", busy); else pass_cnt++;
        run_op(2'd0, 2'd0, 32'hFFFF_FFFB, 32'h0, lat, d, e, b);
        total++; if (d !== 32'h0000_00AA) $display("FAIL enc8 upper got %h want 000000aa", d); else pass_cnt++;
    endtask

    task automatic test_decode;
        int lat; logic [31:0] d; logic [1:0] e; logic b;
        run_op(2'd1, 2'd0, 32'h0000_00A2, 32'h0, lat, d, e, b);
        total++; if (lat !== 2) $display("FAIL dec bit3 latency got %0d want 2", lat); else pass_cnt++;
        total++; if (d !== 32'hB) $display("FAIL dec bit3 data got %h want b", d); else pass_cnt++;
        total++; if (e !== 2'd1) $display("FAIL dec bit3 errors got %0d want 1", e); else pass_cnt++;
        run_op(2'd1, 2'd0, 32'h0000_00AB, 32'h0, lat, d, e, b);
        total++; if (d !== 32'hB) $display("FAIL dec bit0 data got %h want b", d); else pass_cnt++;
        total++; if (e !== 2'd1) $display("FAIL dec bit0 errors got %0d want 1", e); else pass_cnt++;
        run_op(2'd1, 2'd0, 32'hFFFF_FFAA, 32'h0, lat, d, e, b);
        total++; if (d !== 32'hB) $display("FAIL dec clean data got %h want b", d); else pass_cnt++;
        total++; if (e !== 2'd0) $display("FAIL dec clean errors got %0d want 0", e); else pass_cnt++;
        run_op(2'd1, 2'd0, 32'h0000_00A9, 32'h0, lat, d, e, b);
        total++; if (e !== 2'd2) $display("FAIL dec double errors got %0d want 2", e); else pass_cnt++;
    endtask

    task automatic test_full_channel;
        int lat; logic [31:0] d; logic [1:0] e; logic b;
        run_op(2'd2, 2'd0, 32'hB, 32'h0000_000C, lat, d, e, b);
        total++; if (lat !== 4) $display("FAIL chan2 latency got %0d want 4", lat); else pass_cnt++;
        total++; if (e !== 2'd2) $display("FAIL chan2 errors got %0d want 2", e); else pass_cnt++;
        total++; if (d !== 32'hA) $display("FAIL chan2 data got %h want a", d); else pass_cnt++;
        run_op(2'd2, 2'd0, 32'hB, 32'h0, lat, d, e, b);
        total++; if (d !== 32'hB) $display("FAIL chan0 data got %h want b", d); else pass_cnt++;
        total++; if (e !== 2'd0) $display("FAIL chan0 errors got %0d want 0", e); else pass_cnt++;
        run_op(2'd2, 2'd0, 32'hB, 32'h0000_0010, lat, d, e, b);
        total++; if (d !== 32'hB || e !== 2'd1) $display("FAIL chan1 got %h/%0d want b/1", d, e); else pass_cnt++;
        run_op(2'd2, 2'd0, 32'hB, 32'hFFFF_FF00, lat, d, e, b);
        total++; if (d !== 32'hB || e !== 2'd0) $display("FAIL chan upper noise got %h/%0d want b/0", d, e); else pass_cnt++;
    endtask

    task automatic test_illegal;
        int lat; logic [31:0] d; logic [1:0] e; logic b;
        run_op(2'd3, 2'd0, 32'hB, 32'h0, lat, d, e, b);
        total++; if (lat !== 1) $display("FAIL illegal latency got %0d want 1", lat); else pass_cnt++;
        total++; if (d !== 32'h0 || e !== 2'd0) $display("FAIL illegal result got %h/%0d want 0/0", d, e); else pass_cnt++;
    endtask

    task automatic test_width_sweep;
        int lat; logic [31:0] d; logic [1:0] e; logic b;
        int bad;
        run_op(2'd0, 2'd1, 32'h0000_0400, 32'h0, lat, d, e, b);
        total++; if (d !== 32'h0000_8117) $display("FAIL enc16 got %h want 00008117", d); else pass_cnt++;
        run_op(2'd0, 2'd2, 32'h03FF_FFFF, 32'h0, lat, d, e, b);
        total++; if (d !== 32'hFFFF_FFFF) $display("FAIL enc32 got %h want ffffffff", d); else pass_cnt++;
        run_op(2'd0, 2'd3, 32'h0000_0001, 32'h0, lat, d, e, b);
        total++; if (d !== 32'h0000_000F) $display("FAIL enc32w3 got %h want 0000000f", d); else pass_cnt++;
        run_op(2'd1, 2'd1, 32'hABCD_8117, 32'h0, lat, d, e, b);
        total++; if (d !== 32'h400 || e !== 2'd0) $display("FAIL dec16 upper got %h/%0d want 400/0", d, e); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            run_op(2'd1, 2'd1, 32'h0000_8117 ^ (32'd1 << i), 32'h0, lat, d, e, b);
            total++;
            if (lat !== 2 || d !== 32'h400 || e !== 2'd1) begin
                $display("FAIL dec16 flip%0d got %h/%0d lat %0d want 400/1 lat 2", i, d, e, lat);
                bad++;
            end else pass_cnt++;
        end
        for (int i = 0; i < 32; i++) begin
            run_op(2'd1, 2'd2, 32'hFFFF_FFFF ^ (32'd1 << i), 32'h0, lat, d, e, b);
            total++;
            if (lat !== 2 || d !== 32'h03FF_FFFF || e !== 2'd1) begin
                $display("FAIL dec32 flip%0d got %h/%0d lat %0d want 3ffffff/1 lat 2", i, d, e, lat);
                bad++;
            end else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        int dn; logic [31:0] d;
        @(negedge clk);
        CTRL = 32'd0; CODEWORD_WIDTH = 32'd0; DATA_IN = 32'hB; NOISE = 32'h0;
        start = 1'b1;
        @(posedge clk);
        #1;
        DATA_IN = 32'h5;
        dn = 0; d = '0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
            if (operation_done) begin dn++; d = data_out; end
        end
        total++; if (dn !== 1) $display("FAIL busy start dones got %0d want 1", dn); else pass_cnt++;
        total++; if (d !== 32'hAA) $display("FAIL busy start data got %h want aa", d); else pass_cnt++;
        @(negedge clk);
        CTRL = 32'd1; DATA_IN = 32'hA2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        CTRL = 32'd0; DATA_IN = 32'h5;
        start = 1'b1;
        dn = 0; d = '0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
            if (operation_done) begin dn++; d = data_out; end
        end
        total++; if (dn !== 1) $display("FAIL done-cycle start dones got %0d want 1", dn); else pass_cnt++;
        total++; if (d !== 32'hB) $display("FAIL done-cycle start data got %h want b", d); else pass_cnt++;
    endtask

    task automatic test_reset_mid_op;
        int dn; int lat; logic [31:0] d; logic [1:0] e; logic b;
        @(negedge clk);
        CTRL = 32'd2; CODEWORD_WIDTH = 32'd0; DATA_IN = 32'hB; NOISE = 32'h0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (data_out !== 32'h0) $display("FAIL midrst data got %h want 0", data_out); else pass_cnt++;
        total++; if (num_of_errors !== 2'd0) $display("FAIL midrst errors got %0d want 0", num_of_errors); else pass_cnt++;
        total++; if (busy !== 1'b0 || operation_done !== 1'b0) $display("FAIL midrst busy/done got %b/%b want 0/0", busy, operation_done); else pass_cnt++;
        dn = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (operation_done) dn++;
        end
        total++; if (dn !== 0) $display("FAIL midrst dones got %0d want 0", dn); else pass_cnt++;
        run_op(2'd0, 2'd1, 32'h1, 32'h0, lat, d, e, b);
        total++; if (lat !== 2 || d !== 32'hF) $display("FAIL post-rst got %h lat %0d want f lat 2", d, lat); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_encode();
        test_decode();
        test_full_channel();
        test_illegal();
        test_width_sweep();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
